// File: rtl/shift_ctrl.sv
// Iterative shift/rotate sequencer: SHR, SHRA, SHL, ROR, ROL at up to STEP positions per clock.
// Optional SHIFT_CTRL_FASTPATH_EN replaces the STEP-limited stepper with a full 32-bit barrel shift.
module shift_ctrl #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    logic [5:0]  n_ld;
    logic        op_legal;
    logic [5:0]  k;
    logic [5:0]  cnt_next;
    logic [31:0] acc_step;

    // Rotates use a doubled word so the wrap-around bits fall out of one shift.
    function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [2:0] o,
                                             input logic [5:0] amt);
        logic [63:0] t;
        t = 64'd0;
        case (o)
            OP_SHR:  return v >> amt;
            OP_SHRA: return $unsigned($signed(v) >>> amt);
            OP_SHL:  return v << amt;
            OP_ROR: begin
                t = {v, v} >> amt;
                return t[31:0];
            end
            OP_ROL: begin
                t = {v, v} << amt;
                return t[63:32];
            end
            default: return v;
        endcase
    endfunction

    always_comb begin
        op_legal = (op <= OP_ROL);
        n_ld     = 6'd0;
        case (op)
            OP_SHR, OP_SHRA, OP_SHL: n_ld = (|b[31:5]) ? 6'd32 : {1'b0, b[4:0]};
            OP_ROR, OP_ROL:          n_ld = {1'b0, b[4:0]};
            default:                 n_ld = 6'd0;
        endcase
    end

`ifdef SHIFT_CTRL_FASTPATH_EN
    always_comb begin
        k        = cnt_q;
        acc_step = shift_by(acc_q, op_q, cnt_q);
    end
`else
    localparam logic [5:0] STEP_W = 6'(STEP);

    // Only constant shifts of 1..STEP are built, selected by k.
    always_comb begin
        k        = (cnt_q > STEP_W) ? STEP_W : cnt_q;
        acc_step = acc_q;
        for (int j = 1; j <= STEP; j++) begin
            if (k == j[5:0]) acc_step = shift_by(acc_q, op_q, j[5:0]);
        end
    end
`endif

    assign cnt_next = cnt_q - k;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    op_d    = op;
                    acc_d   = op_legal ? a : 32'd0;
                    cnt_d   = n_ld;
                    state_d = (n_ld == 6'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // The step taken in the abort cycle still lands in the accumulator.
                acc_d = acc_step;
                cnt_d = cnt_next;
                if (abort)                   state_d = IDLE;
                else if (cnt_next == 6'd0)   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            cnt_q   <= 6'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = acc_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized + directed bench for shift_ctrl against a whole-operation reference model.
module tb_shift_ctrl;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    shift_ctrl #(.STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op(op), .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ref_n(input logic [2:0] o, input logic [31:0] bv);
        if (o > 3'd4) return 0;
        if (o >= 3'd3) return int'(bv % 32);
        if (bv >= 32) return 32;
        return int'(bv);
    endfunction

    // Whole result in one step, straight from the op definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] av, input int n);
        logic [63:0] ext;
        case (o)
            3'd0: return (n >= 32) ? 32'd0 : av >> n;
            3'd1: begin
                ext = {{32{av[31]}}, av} >> n;
                return ext[31:0];
            end
            3'd2: return (n >= 32) ? 32'd0 : av << n;
            3'd3: return (n == 0) ? av : ((av >> n) | (av << (32 - n)));
            3'd4: return (n == 0) ? av : ((av << n) | (av >> (32 - n)));
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int n);
`ifdef SHIFT_CTRL_FASTPATH_EN
        return (n == 0) ? 1 : 2;
`else
        return 1 + (n + STEP - 1) / STEP;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input bit junk);
        int n, lat;
        bit seen;
        logic [31:0] exp_res;
        n       = ref_n(o, bv);
        exp_res = ref_res(o, av, n);
        seen    = 1'b0;
        lat     = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (junk) begin
                start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                lat  = c;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            end else begin
                chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(n)));
        chk({tag, "_result"}, result, exp_res);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("shr4",    3'd0, 32'h8000_0000, 32'd4,  1'b0);
        run_op("shra40",  3'd1, 32'hF000_0000, 32'd40, 1'b0);
        run_op("shl40",   3'd2, 32'hFFFF_FFFF, 32'd40, 1'b0);
        run_op("rol33",   3'd4, 32'h8000_0001, 32'h21, 1'b0);
        run_op("ror32",   3'd3, 32'h1234_5678, 32'd32, 1'b0);
        run_op("illegal", 3'd6, 32'h1234_5678, 32'd3,  1'b0);
        run_op("shra31_junk", 3'd1, 32'h8765_4321, 32'd31, 1'b1);
        run_op("ror5_junk",   3'd3, 32'hDEAD_BEEF, 32'd5,  1'b1);
        run_op("ror8",    3'd3, 32'h0000_00FF, 32'd8,  1'b0);

`ifndef SHIFT_CTRL_FASTPATH_EN
        // Abort in the third RUN cycle: three STEP-sized shifts have landed.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1; b = 32'd31;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, ref_res(3'd2, 32'd1, 3 * STEP));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
`endif

        // Abort coincident with start in IDLE wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 1'($urandom));
        end

        // Reset mid-RUN clears everything without waiting for an edge.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'hF000_0000; b = 32'd40;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'd2, 32'h0000_0001, 32'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
